// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering memory-stage loads/stores.
// Ports: clk, rst (async low), req_* handshake in, resp_* strobe out, stall.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          accept;
  logic          enter_resp;
  logic          bad;
  logic          mem_we;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_ready = (state_q != WAIT);
    accept    = req_valid & req_ready;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address check and memory access use the request as it will be
  // captured, so LATENCY=1 sees the request accepted on this edge.
  always_comb begin
    enter_resp = (state_d == RESP);
    bad = (addr_d[1:0] != 2'b00)
        | ({2'b00, addr_d[31:2]} >= 32'(DEPTH));
    idx     = addr_d[AW+1:2];
    mem_we  = rst & enter_resp & we_d & ~bad;
    rdata_d = '0;
    err_d   = enter_resp & bad;
    if (enter_resp & ~we_d & ~bad) rdata_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign stall      = req_valid & ~req_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Two builds: LATENCY=2 (main) and LATENCY=1 (streaming).
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v0, we0, rdy0, rv0, err0, st0;
  logic [31:0] a0, wd0, rd0;
  logic        v1, we1, rdy1, rv1, err1, st1;
  logic [31:0] a1, wd1, rd1;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
    .stall(st0)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
    .stall(st1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst) begin
      if (rv0) begin
        if (q0.size() == 0) begin
          fail_now("m0_unexpected_resp");
        end else begin
          e = q0.pop_front();
          check("m0_rdata", rd0, e.d);
          check("m0_err", 32'(err0), 32'(e.e));
          check("m0_latency", 32'(cyc - e.c), 32'd2);
        end
      end else begin
        check("m0_idle_rdata", rd0, 32'h0);
        check("m0_idle_err", 32'(err0), 32'h0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      if (rv1) begin
        if (q1.size() == 0) begin
          fail_now("m1_unexpected_resp");
        end else begin
          e = q1.pop_front();
          check("m1_rdata", rd1, e.d);
          check("m1_err", 32'(err1), 32'(e.e));
          check("m1_latency", 32'(cyc - e.c), 32'd1);
        end
      end else begin
        check("m1_idle_rdata", rd1, 32'h0);
        check("m1_idle_err", 32'(err1), 32'h0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after accept.
  task automatic issue0(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] ed,
                        input logic ee,
                        input bit expect_resp);
    int n;
    n = 0;
    v0 = 1'b1;
    we0 = we;
    a0 = a;
    wd0 = wd;
    while (!rdy0 && n < 10) begin
      check("stall0_wait", 32'(st0), 32'h1);
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      fail_now("issue0_timeout");
    end else begin
      check("stall0_ready", 32'(st0), 32'h0);
      if (expect_resp) q0.push_back('{ed, ee, cyc});
    end
    @(negedge clk);
  endtask

  task automatic idle0(input int n);
    v0 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic issue1(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] ed,
                        input logic ee);
    v1 = 1'b1;
    we1 = we;
    a1 = a;
    wd1 = wd;
    check("rdy1_stream", 32'(rdy1), 32'h1);
    check("stall1_stream", 32'(st1), 32'h0);
    q1.push_back('{ed, ee, cyc});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(rdy0), 32'h1);
    check("rst_valid0", 32'(rv0), 32'h0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_err0", 32'(err0), 32'h0);
    check("rst_stall0", 32'(st0), 32'h0);
    check("rst_ready1", 32'(rdy1), 32'h1);
    check("rst_valid1", 32'(rv1), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // store then load
    issue0(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    idle0(3);
    issue0(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    idle0(3);

    // back-to-back with req_valid held high
    issue0(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);
    issue0(1'b1, 32'h20, 32'hEDCBA987, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h20, 32'h0, 32'hEDCBA987, 1'b0, 1'b1);
    idle0(3);

    // error accesses leave memory alone
    issue0(1'b1, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    issue0(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
    issue0(1'b1, 32'h01, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    issue0(1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    idle0(3);

    // reset mid-WAIT drops the store
    issue0(1'b1, 32'h08, 32'h11111111, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h08, 32'h0, 32'h11111111, 1'b0, 1'b1);
    idle0(3);
    issue0(1'b1, 32'h08, 32'hAAAA0000, 32'h0, 1'b0, 1'b0);
    v0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(rv0), 32'h0);
    check("abort_ready", 32'(rdy0), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue0(1'b0, 32'h08, 32'h0, 32'h11111111, 1'b0, 1'b1);
    idle0(3);

    // last word and first out-of-range word
    issue0(1'b1, 32'h3FC, 32'h5A5AA5A5, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h3FC, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b1);
    issue0(1'b1, 32'h400, 32'h77777777, 32'h0, 1'b1, 1'b1);
    issue0(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
    issue0(1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    issue0(1'b0, 32'h3FC, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b1);
    idle0(3);

    // LATENCY=1 streaming
    issue1(1'b1, 32'h40, 32'hA1A1A1A1, 32'h0, 1'b0);
    issue1(1'b0, 32'h40, 32'h0, 32'hA1A1A1A1, 1'b0);
    issue1(1'b1, 32'h44, 32'hB2B2B2B2, 32'h0, 1'b0);
    issue1(1'b0, 32'h44, 32'h0, 32'hB2B2B2B2, 1'b0);
    issue1(1'b0, 32'h40, 32'h0, 32'hA1A1A1A1, 1'b0);
    issue1(1'b1, 32'h40, 32'hC3C3C3C3, 32'h0, 1'b0);
    issue1(1'b0, 32'h40, 32'h0, 32'hC3C3C3C3, 1'b0);
    issue1(1'b0, 32'h402, 32'h0, 32'h0, 1'b1);
    v1 = 1'b0;

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
